// File: rtl/mod12_counter_load_arbiter_pkg.sv
// Shared types and defaults for the mod-12 counter load arbiter.
// Holds the FSM state encoding, owner encoding, round-robin pointer values
// and default counter geometry.
package mod12_counter_load_arbiter_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int MOD_DEF   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    // Round-robin pointer: names the side that wins a simultaneous request.
    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

endpackage

// File: rtl/mod12_counter_load_arbiter_rr_arbiter_2.sv
// Combinational 2-way round-robin pick.
// Ports: req_a/req_b requests, rr_ptr priority side; win_a/win_b one-hot winner
// (both low when nobody requests). A lone request wins regardless of rr_ptr.
module rr_arbiter_2
    import mod12_counter_load_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic rr_ptr,
    output logic win_a,
    output logic win_b
);

    assign win_a = req_a && (!req_b || (rr_ptr == RR_A));
    assign win_b = req_b && (!req_a || (rr_ptr == RR_B));

endmodule

// File: rtl/mod12_counter_load_arbiter.sv
// Shares one loadable mod-MOD up counter between requesters A and B: grants,
// loads the owner's (range-clamped) preset, runs WRAPS wraps, then releases.
// Ports: clk/rst; req_x/data_x from requesters; cnt_q from the counter;
// cnt_data/cnt_load_en/cnt_rst to the counter; gnt_a/gnt_b/busy/wrap_pulse/
// load_clamped status.
module mod12_counter_load_arbiter
    import mod12_counter_load_arbiter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int MOD   = MOD_DEF,
    parameter int WRAPS = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [CNT_W-1:0] data_a,
    input  logic             req_b,
    input  logic [CNT_W-1:0] data_b,
    input  logic [CNT_W-1:0] cnt_q,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_load_en,
    output logic             cnt_rst,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             busy,
    output logic             wrap_pulse,
    output logic             load_clamped
);

    localparam logic [CNT_W-1:0] TERM     = CNT_W'(MOD - 1);
    localparam logic [3:0]       LAST_LAP = 4'(WRAPS - 1);

    state_t           state, state_nxt;
    owner_t           owner, owner_nxt;
    logic             rr_ptr, rr_ptr_nxt;
    logic [3:0]       wrap_cnt, wrap_cnt_nxt;
    logic [CNT_W-1:0] preset, preset_nxt;
    logic             clamp, clamp_nxt;

    logic             win_a, win_b;
    logic [CNT_W-1:0] sel_data;
    logic             owner_req;
    logic             wrap_ev;

    rr_arbiter_2 u_arb (
        .req_a  (req_a),
        .req_b  (req_b),
        .rr_ptr (rr_ptr),
        .win_a  (win_a),
        .win_b  (win_b)
    );

    assign sel_data  = win_a ? data_a : data_b;
    assign owner_req = (owner == OWN_A) ? req_a : req_b;
    assign wrap_ev   = (state == RUN) && (cnt_q == TERM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_NONE;
            rr_ptr   <= RR_A;
            wrap_cnt <= '0;
            preset   <= '0;
            clamp    <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            wrap_cnt <= wrap_cnt_nxt;
            preset   <= preset_nxt;
            clamp    <= clamp_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        wrap_cnt_nxt = wrap_cnt;
        preset_nxt   = preset;
        clamp_nxt    = clamp;
        unique case (state)
            IDLE: begin
                owner_nxt = OWN_NONE;
                if (win_a || win_b) begin
                    owner_nxt    = win_a ? OWN_A : OWN_B;
                    wrap_cnt_nxt = '0;
                    state_nxt    = LOAD;
                    // Out-of-range presets are latched as 0 and flagged.
                    if (sel_data > TERM) begin
                        preset_nxt = '0;
                        clamp_nxt  = 1'b1;
                    end else begin
                        preset_nxt = sel_data;
                        clamp_nxt  = 1'b0;
                    end
                end
            end
            // Request level is deliberately not looked at here, so a
            // release requested during LOAD lands in the first RUN cycle.
            LOAD: state_nxt = RUN;
            RUN: begin
                if (wrap_ev) begin
                    wrap_cnt_nxt = wrap_cnt + 4'd1;
                end
                if ((wrap_ev && (wrap_cnt == LAST_LAP)) || !owner_req) begin
                    state_nxt    = IDLE;
                    owner_nxt    = OWN_NONE;
                    rr_ptr_nxt   = (owner == OWN_A) ? RR_B : RR_A;
                    wrap_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

    // owner is only non-NONE in LOAD/RUN, so grants come straight off flops.
    assign gnt_a        = (owner == OWN_A);
    assign gnt_b        = (owner == OWN_B);
    assign busy         = (state == LOAD) || (state == RUN);
    assign cnt_load_en  = (state == LOAD);
    assign cnt_data     = (state == LOAD) ? preset : '0;
    assign load_clamped = (state == LOAD) && clamp;
    assign cnt_rst      = !((state == LOAD) || (state == RUN));
    assign wrap_pulse   = wrap_ev;

endmodule

// File: doc/mod12_counter_load_arbiter.md
Name: mod12_counter_load_arbiter

Overview:
Controller and arbiter that shares one loadable mod-12 up counter between two requesters (A and B).
- Grants the counter to one requester at a time and loads that requester's preset value.
- Lets the counter run for a programmed number of wraps, then releases it.
- Holds the counter in reset while it is idle.
- Sits between the requesting blocks and the counter's data/load_en/rst inputs, and watches the counter's q output.

Parameters:
CNT_W, 4, counter width in bits.
MOD, 12, counter modulus. The counter's terminal value is MOD-1.
WRAPS, 1, number of wrap events (q = MOD-1 -> 0) before the grant is released. Legal range 1..15.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
req_a  input  1  requester A wants the counter; held high while it wants to keep it.
data_a  input  CNT_W  requester A preset value.
req_b  input  1  requester B wants the counter.
data_b  input  CNT_W  requester B preset value.
cnt_q  input  CNT_W  current counter value.
cnt_data  output  CNT_W  preset value driven to the counter.
cnt_load_en  output  1  counter load enable.
cnt_rst  output  1  counter reset (synchronous, active-high).
gnt_a  output  1  A owns the counter.
gnt_b  output  1  B owns the counter.
busy  output  1  the counter is owned (state is LOAD or RUN).
wrap_pulse  output  1  the owned counter is at its terminal value this cycle.
load_clamped  output  1  the preset was out of range and was replaced by 0.

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high.
- Values forced by reset:
  - state = IDLE, owner = none, rr_ptr = A (A has priority), wrap_cnt = 0.
  - gnt_a = gnt_b = 0, busy = 0, cnt_load_en = 0, cnt_data = 0, wrap_pulse = 0, load_clamped = 0.
  - cnt_rst = 1.
- States:
  - IDLE: cnt_rst = 1.
    - If any req is high, arbitrate, register owner and preset, go to LOAD.
    - Both requests high: rr_ptr side wins.
    - One request high: that side wins regardless of rr_ptr.
  - LOAD (exactly 1 cycle): cnt_load_en = 1, cnt_data = latched preset, cnt_rst = 0. Always go to RUN.
  - RUN: cnt_load_en = 0, cnt_rst = 0, the counter free-runs.
    - Wrap event: cnt_q == MOD-1 in RUN. wrap_pulse follows it combinationally. wrap_cnt increments on each wrap event.
    - Go to IDLE when the wrap event occurs with wrap_cnt == WRAPS-1, or when the owner's req is low (early release).
    - If both conditions hold in the same cycle, go to IDLE; the outcome is identical either way.
- Grant outputs:
  - gnt_x and busy are registered and high throughout LOAD and RUN for the owner.
  - They drop in the first IDLE cycle.
  - Never gnt_a && gnt_b.
- Round-robin: on leaving RUN, rr_ptr points to the non-owner. A requester still holding req re-arbitrates in IDLE (minimum 1 IDLE cycle between grants).
- Latency:
  - req rises (sampled in IDLE) at edge t -> gnt/busy high and state LOAD after edge t.
  - Counter shows the preset after edge t+1.
- Range clamp:
  - Preset > MOD-1 is loaded as 0.
  - load_clamped is high for the LOAD cycle only.
- Request changes after grant: data_x changes after the grant are ignored (the preset is latched at arbitration).
- Reset mid-operation: rst in LOAD or RUN returns the block to IDLE at that edge with all reset values, and cnt_rst = 1 from the next cycle.
- Early release: req dropped during LOAD is ignored; the release is taken in the first RUN cycle.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2.
  - Owner encoding: NONE, A, B.
  - MOD/CNT_W defaults.
- One natural sub-module: rr_arbiter_2. It is a combinational 2-way round-robin pick from {req_a, req_b, rr_ptr} that outputs a winner one-hot.
- The FSM, latches and wrap counter stay in the top module.

Test Plan:
1. rst = 1 for 2 cycles, no req -> cnt_rst = 1, gnt_a = gnt_b = 0, busy = 0, cnt_load_en = 0.
2. req_a = 1, data_a = 2, WRAPS = 1, counter model attached:
   - LOAD cycle with cnt_data = 2, cnt_load_en = 1.
   - RUN shows cnt_q 2..11 (10 cycles); wrap_pulse is high at cnt_q = 11.
   - Next cycle IDLE, gnt_a = 0, cnt_rst = 1.
3. req_a = req_b = 1 held continuously after reset (data_a = 5, data_b = 9) -> grant order A, B, A. Each grant is preceded by exactly one IDLE cycle.
4. req_b alone, data_b = 14 -> cnt_data = 0, load_clamped = 1 for the LOAD cycle only; the counter runs 0..11.
5. req_a = 1, data_a = 0, WRAPS = 3; drop req_a when cnt_q = 5 in the first lap -> IDLE next edge, no wrap_pulse seen, rr_ptr = B.
6. rst pulsed for one cycle while in RUN with cnt_q = 7 owned by B -> IDLE at that edge, gnt_b = 0, rr_ptr = A; a later simultaneous request is granted to A.
